sti_rx: RTL and testbench
=========================

Name: sti_rx

Overview:
- Serial-to-parallel receiver: the receive end of the STI serial link (so_data/so_valid).
- Deserialises one burst of 8/16/24/32 bits and reconstructs the original 16-bit parallel word.
- Honours the same length, bit-order, fill and low-byte configuration as the transmitter.
- Buffers results in a small FIFO with a valid/ready handshake toward the consumer, and flags malformed bursts.

Parameters:
- FIFO_DEPTH, 2, number of reconstructed words held; power of 2, minimum 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- so_data  in  1  serial data bit
- so_valid  in  1  so_data is valid this cycle; high for the full burst
- cfg_msb  in  1  1 = burst is MSB-first
- cfg_length  in  2  00=8, 01=16, 10=24, 11=32 bits
- cfg_fill  in  1  24/32-bit mode: 1 = payload in upper bits, 0 = payload in lower bits
- cfg_low  in  1  8-bit mode: 1 = byte came from pi_data[15:8]
- po_data  out  16  reconstructed word at FIFO head
- po_pad_err  out  1  the head word had non-zero padding bits
- po_valid  out  1  FIFO non-empty
- po_ready  in  1  consumer accepts the head word when po_valid & po_ready
- frame_err  out  1  one-cycle pulse: burst ended short
- ovf  out  1  sticky: a completed word was dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, ovf cleared. Reset mid-burst discards the partial word.
- Configuration is sampled on the first so_valid cycle of a burst and held until the burst ends. cfg_* changes mid-burst are ignored.
- FSM:
  - IDLE: on so_valid=1, capture cfg, store bit 0 of the burst, set cnt=1, go to RECV.
  - RECV: on so_valid=1, store the bit and increment cnt. When the stored bit is bit L-1, the word completes (push) and the FSM returns to IDLE.
  - RECV with so_valid=0 before L bits: pulse frame_err for 1 cycle, discard the partial word, go to IDLE.
  - so_valid remaining high after the last bit starts a new burst on the next cycle, with cfg resampled.
- Assembly: define W[L-1:0], with L = 8/16/24/32.
  - MSB-first: the k-th received bit (k from 0) is W[L-1-k].
  - LSB-first: the k-th received bit is W[k].
- Extraction into po_data, with the padding bits that are checked for zero:
  - 8-bit, low=1: {W[7:0], 8'h00}.
  - 8-bit, low=0: {8'h00, W[7:0]}.
  - 16-bit: W[15:0]; no padding.
  - 24-bit, fill=1: W[23:8]; pad = W[7:0].
  - 24-bit, fill=0: W[15:0]; pad = W[23:16].
  - 32-bit, fill=1: W[31:16]; pad = W[15:0].
  - 32-bit, fill=0: W[15:0]; pad = W[31:16].
  - pad_err = OR of the pad bits; it is stored in the FIFO with the word.
- Latency: if the last bit is sampled at edge t and the FIFO was empty, po_valid=1 with the word after edge t (visible in cycle t+1).
- FIFO:
  - Push occurs on word completion; pop occurs on po_valid & po_ready. Order is first in, first out.
  - Push and pop in the same cycle while full: both take effect and the word is accepted.
  - Push while full with no pop: the word is dropped, ovf set to 1, and ovf stays 1 until reset.
  - Pop while empty: ignored.
- Pointers wrap modulo FIFO_DEPTH. The occupancy counter is log2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Shared package sti_pkg:
  - length codes LEN_8/16/24/32 and the length-to-bit-count function;
  - FSM state enum {IDLE, RECV};
  - FIFO entry typedef {pad_err, data[15:0]}.
- Sub-module sti_rx_fifo: parameterised synchronous FIFO carrying the entry type, with push/pop/full/empty. It also sets ovf on a push into a full FIFO without a pop.

Test Plan:
- 16-bit MSB-first burst of 0xA5C3, po_ready=1 -> po_valid pulses 1 cycle after the last bit with po_data=0xA5C3 and po_pad_err=0.
- 8-bit LSB-first, low=1, byte 0x3C -> po_data=0x3C00. Repeat with low=0 -> po_data=0x003C.
- 32-bit fill=1, MSB-first, payload 0x1234 followed by 16 zeros -> po_data=0x1234, pad_err=0. Inject a 1 in the padding -> po_pad_err=1.
- 24-bit burst with so_valid dropped after 10 bits -> frame_err pulses once, nothing pushed, next 16-bit burst of 0xBEEF is received correctly.
- po_ready=0 while 3 back-to-back 8-bit bursts arrive (FIFO_DEPTH=2) -> first two words are held and ovf=1. Raise po_ready -> the two words drain in order.
- Assert reset (reset=0) in the middle of a 32-bit burst -> all outputs 0 and FIFO empty. After release, a fresh 16-bit burst of 0x0001 is received correctly.

Source files
------------

// File: rtl/sti_rx_pkg.sv
// Shared types and constants for the STI serial link receiver.
//   LEN_* : cfg_length codes (8/16/24/32-bit bursts)
//   len_bits() : burst length code -> number of bits in the burst
//   sti_state_e : receiver FSM states
//   sti_entry_t : FIFO entry (reconstructed word plus padding-error flag)
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  function automatic logic [5:0] len_bits(input logic [1:0] len);
    case (len)
      LEN_8:   return 6'd8;
      LEN_16:  return 6'd16;
      LEN_24:  return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

  typedef enum logic {IDLE, RECV} sti_state_e;

  typedef struct packed {
    logic        pad_err;
    logic [15:0] data;
  } sti_entry_t;

endpackage

// File: rtl/sti_rx_if.sv
// Bus bundle for sti_rx.
//   serial side : so_data, so_valid, cfg_msb/length/fill/low
//   parallel side : po_data, po_pad_err, po_valid, po_ready
//   status : frame_err (1-cycle pulse), ovf (sticky)
// master = stimulus/consumer side, slave = the receiver.
interface sti_rx_if;
  logic        so_data;
  logic        so_valid;
  logic        cfg_msb;
  logic [1:0]  cfg_length;
  logic        cfg_fill;
  logic        cfg_low;
  logic [15:0] po_data;
  logic        po_pad_err;
  logic        po_valid;
  logic        po_ready;
  logic        frame_err;
  logic        ovf;

  modport master (
    output so_data, so_valid, cfg_msb, cfg_length, cfg_fill, cfg_low, po_ready,
    input  po_data, po_pad_err, po_valid, frame_err, ovf
  );

  modport slave (
    input  so_data, so_valid, cfg_msb, cfg_length, cfg_fill, cfg_low, po_ready,
    output po_data, po_pad_err, po_valid, frame_err, ovf
  );
endinterface

// File: rtl/sti_rx_fifo.sv
// Small synchronous FIFO of sti_entry_t words.
//   push/din : write a completed word (dropped when full unless popping)
//   pop      : remove head (ignored when empty)
//   head     : word at the head, zero while empty
//   full/empty : occupancy flags
//   ovf      : sticky, set when a word is dropped on a full FIFO
module sti_rx_fifo
  import sti_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  sti_entry_t din,
  input  logic       pop,
  output sti_entry_t head,
  output logic       full,
  output logic       empty,
  output logic       ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sti_entry_t      mem_q [DEPTH];
  sti_entry_t      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign ovf   = ovf_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // is still accepted when the head is being consumed.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push & full & ~rd_en);
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: rtl/sti_rx.sv
// STI serial-to-parallel receiver.
// Deserialises an 8/16/24/32-bit burst on so_data/so_valid, rebuilds the
// 16-bit word using the sampled cfg_* settings, and queues it with its
// padding-error flag toward a valid/ready consumer.
//   clk, reset (async, active low)
//   bus : sti_rx_if.slave (serial in, cfg, parallel out, frame_err, ovf)
module sti_rx
  import sti_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input logic     clk,
  input logic     reset,
  sti_rx_if.slave bus
);
  sti_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] w_q, w_d;
  logic        msb_q, msb_d, fill_q, fill_d, low_q, low_d;
  logic [1:0]  len_q, len_d;
  logic        frame_err_q, frame_err_d;
  logic        push;
  sti_entry_t  ent, head;
  logic        full, empty;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    msb_d       = msb_q;
    len_d       = len_q;
    fill_d      = fill_q;
    low_d       = low_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: if (bus.so_valid) begin
        // Bit 0 lands in W[0] either way: MSB-first then shifts it up,
        // LSB-first indexes subsequent bits by count.
        msb_d   = bus.cfg_msb;
        len_d   = bus.cfg_length;
        fill_d  = bus.cfg_fill;
        low_d   = bus.cfg_low;
        w_d     = {31'b0, bus.so_data};
        cnt_d   = 6'd1;
        state_d = RECV;
      end
      RECV: if (bus.so_valid) begin
        if (msb_q) w_d = {w_q[30:0], bus.so_data};
        else       w_d[cnt_q[4:0]] = bus.so_data;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == len_bits(len_q) - 6'd1) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end else begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word extraction works on w_d so the completing bit is included.
  always_comb begin
    ent = '0;
    case (len_q)
      LEN_8:  ent.data = low_q ? {w_d[7:0], 8'h00} : {8'h00, w_d[7:0]};
      LEN_16: ent.data = w_d[15:0];
      LEN_24: begin
        ent.data    = fill_q ? w_d[23:8]   : w_d[15:0];
        ent.pad_err = fill_q ? |w_d[7:0]   : |w_d[23:16];
      end
      default: begin
        ent.data    = fill_q ? w_d[31:16]  : w_d[15:0];
        ent.pad_err = fill_q ? |w_d[15:0]  : |w_d[31:16];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      msb_q       <= 1'b0;
      len_q       <= LEN_8;
      fill_q      <= 1'b0;
      low_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      msb_q       <= msb_d;
      len_q       <= len_d;
      fill_q      <= fill_d;
      low_q       <= low_d;
      frame_err_q <= frame_err_d;
    end
  end

  sti_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ent),
    .pop   (bus.po_ready),
    .head  (head),
    .full  (full),
    .empty (empty),
    .ovf   (bus.ovf)
  );

  assign bus.po_valid   = ~empty;
  assign bus.po_data    = head.data;
  assign bus.po_pad_err = head.pad_err;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_sti_rx.sv
// Directed bench for sti_rx: bursts are driven #1 after the rising edge,
// expected words are queued when a burst is sent and compared at the
// falling edge whenever the DUT hands a word to the consumer.
module tb_sti_rx;
  import sti_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sti_rx_if bus ();

  sti_rx #(.FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int fe_cnt = 0;
  logic [16:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference word for a burst: {pad_err, data}.
  function automatic logic [16:0] model(input logic [1:0] len, input logic fill,
                                        input logic low, input logic [31:0] w);
    case (len)
      2'd0:    return low ? {1'b0, w[7:0], 8'h00} : {1'b0, 8'h00, w[7:0]};
      2'd1:    return {1'b0, w[15:0]};
      2'd2:    return fill ? {|w[7:0], w[23:8]} : {|w[23:16], w[15:0]};
      default: return fill ? {|w[15:0], w[31:16]} : {|w[31:16], w[15:0]};
    endcase
  endfunction

  // Consumer-side monitor.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.frame_err === 1'b1) fe_cnt++;
      if (bus.po_valid === 1'b1 && bus.po_ready === 1'b1) begin
        n_vec++;
        assert (exp_q.size() != 0)
        else begin
          n_err++;
          $error("FAIL pop_unexpected observed=%0h expected=none", {bus.po_pad_err, bus.po_data});
        end
        if (exp_q.size() != 0) chk("po_word", {bus.po_pad_err, bus.po_data}, exp_q.pop_front());
      end
    end
  end

  // Drives nb bits; cfg is scrambled after the first bit to show it is ignored.
  task automatic burst(input logic [1:0] len, input logic msb, input logic fill,
                       input logic low, input logic [31:0] w, input int nb,
                       input bit exp_push);
    int L;
    L = 8 * (int'(len) + 1);
    for (int k = 0; k < nb; k++) begin
      @(posedge clk); #1;
      bus.so_valid = 1'b1;
      bus.so_data  = msb ? w[L-1-k] : w[k];
      if (k == 0) begin
        bus.cfg_msb = msb; bus.cfg_length = len; bus.cfg_fill = fill; bus.cfg_low = low;
      end else begin
        bus.cfg_msb = ~msb; bus.cfg_length = ~len; bus.cfg_fill = ~fill; bus.cfg_low = ~low;
      end
    end
    if (exp_push) exp_q.push_back(model(len, fill, low, w));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.so_valid = 1'b0;
      bus.so_data  = 1'b0;
    end
  endtask

  initial begin
    bus.so_data = 0; bus.so_valid = 0; bus.cfg_msb = 0; bus.cfg_length = 0;
    bus.cfg_fill = 0; bus.cfg_low = 0; bus.po_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_po_valid",  bus.po_valid,   0);
    chk("rst_po_data",   bus.po_data,    0);
    chk("rst_pad_err",   bus.po_pad_err, 0);
    chk("rst_frame_err", bus.frame_err,  0);
    chk("rst_ovf",       bus.ovf,        0);
    reset = 1'b1;
    bus.po_ready = 1'b1;
    idle(2);

    // 16-bit MSB-first, word visible the cycle after the last bit
    burst(LEN_16, 1, 0, 0, 32'h0000_A5C3, 16, 1);
    idle(1);
    chk("lat_po_valid", bus.po_valid, 1);
    chk("lat_po_data",  bus.po_data,  16'hA5C3);
    chk("lat_pad_err",  bus.po_pad_err, 0);
    idle(2);
    chk("drained_16", bus.po_valid, 0);

    // 8-bit LSB-first, high and low byte lanes
    burst(LEN_8, 0, 0, 1, 32'h0000_003C, 8, 1);
    idle(2);
    burst(LEN_8, 0, 0, 0, 32'h0000_003C, 8, 1);
    idle(2);

    // 32-bit fill=1 MSB-first, clean then dirty padding
    burst(LEN_32, 1, 1, 0, 32'h1234_0000, 32, 1);
    idle(2);
    burst(LEN_32, 1, 1, 0, 32'h1234_0100, 32, 1);
    idle(2);
    // 24-bit fill=0 LSB-first with dirty upper padding
    burst(LEN_24, 0, 0, 0, 32'h0080_5A5A, 24, 1);
    idle(2);

    // Short 24-bit burst, then a good 16-bit burst
    burst(LEN_24, 1, 1, 0, 32'h00FF_FFFF, 10, 0);
    idle(4);
    chk("frame_err_once", fe_cnt, 1);
    chk("no_push_on_short", bus.po_valid, 0);
    burst(LEN_16, 1, 0, 0, 32'h0000_BEEF, 16, 1);
    idle(3);

    // Overflow: three back-to-back bytes into a depth-2 FIFO
    bus.po_ready = 1'b0;
    burst(LEN_8, 1, 0, 0, 32'h0000_0011, 8, 1);
    burst(LEN_8, 1, 0, 0, 32'h0000_0022, 8, 1);
    burst(LEN_8, 1, 0, 0, 32'h0000_0033, 8, 0);
    idle(2);
    chk("ovf_set",       bus.ovf,      1);
    chk("ovf_held_valid", bus.po_valid, 1);
    chk("ovf_head",      bus.po_data,  16'h0011);
    bus.po_ready = 1'b1;
    idle(4);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_empty",   bus.po_valid, 0);
    chk("ovf_sticky",  bus.ovf,      1);

    // Reset in the middle of a 32-bit burst
    burst(LEN_32, 1, 1, 0, 32'hDEAD_BEEF, 12, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_po_valid",  bus.po_valid,  0);
    chk("midrst_po_data",   bus.po_data,   0);
    chk("midrst_frame_err", bus.frame_err, 0);
    chk("midrst_ovf",       bus.ovf,       0);
    idle(2);
    reset = 1'b1;
    burst(LEN_16, 0, 0, 0, 32'h0000_0001, 16, 1);
    idle(3);
    chk("final_sb_empty",  exp_q.size(), 0);
    chk("frame_err_total", fe_cnt, 1);
    chk("final_ovf_clear", bus.ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
